// File: rtl/dsp_pkg.sv
// dsp_pkg: instruction format shared by the sequencer and the DSP core
package dsp_pkg;
    localparam int OPC_W   = 6;
    localparam int ADDR_W  = 10;
    localparam int INSTR_W = OPC_W + 2 * ADDR_W;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP   = 6'd0,
        OP_LOAD  = 6'd1,
        OP_MAC   = 6'd2,
        OP_STORE = 6'd3,
        OP_OUT   = 6'd4
    } opcode_t;

    typedef struct packed {
        opcode_t             opcode;
        logic [ADDR_W-1:0]   sample_addr;
        logic [ADDR_W-1:0]   param_addr;
    } instr_t;

    localparam instr_t INSTR_NOP = '0;
endpackage

// File: rtl/dsp_sequencer_if.sv
// dsp_sequencer_if: frame control, status and program-memory port of the sequencer
interface dsp_sequencer_if #(
    parameter int INSTR_WIDTH = 26,
    parameter int PC_WIDTH    = 10
);
    logic                   enable;
    logic                   sample_tick;
    logic                   overrun_clr;
    logic [PC_WIDTH-1:0]    prog_last;
    logic [PC_WIDTH-1:0]    prog_rd_addr;
    logic [INSTR_WIDTH-1:0] prog_rd_data;
    logic [INSTR_WIDTH-1:0] instruction;
    logic                   busy;
    logic                   frame_done;
    logic                   overrun;

    modport master (
        output enable, sample_tick, overrun_clr, prog_last, prog_rd_data,
        input  prog_rd_addr, instruction, busy, frame_done, overrun
    );

    modport slave (
        input  enable, sample_tick, overrun_clr, prog_last, prog_rd_data,
        output prog_rd_addr, instruction, busy, frame_done, overrun
    );
endinterface

// File: rtl/dsp_sequencer.sv
// dsp_sequencer: issues one pass of the DSP program per audio frame, then drains the core pipeline
module dsp_sequencer
    import dsp_pkg::*;
#(
    parameter int INSTR_WIDTH  = INSTR_W,
    parameter int PC_WIDTH     = 10,
    parameter int DRAIN_CYCLES = 4
) (
    input logic            clk,
    input logic            reset_n,
    dsp_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, RUN, DRAIN} state_t;

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    state_t              state, state_nxt;
    logic [PC_WIDTH-1:0] pc, pc_nxt, last_pc;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                last_rd;
    logic                overrun;
    logic                start;

    assign start = state == IDLE && bus.sample_tick && bus.enable;

    // Next state, pc advance (saturating at the latched last address) and drain countdown
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = cnt;
        case (state)
            IDLE:  state_nxt = start ? FETCH : IDLE;
            FETCH: begin
                state_nxt = RUN;
                pc_nxt    = pc != last_pc ? pc + 1'b1 : pc;
            end
            RUN: begin
                pc_nxt    = pc != last_pc ? pc + 1'b1 : pc;
                state_nxt = last_rd ? DRAIN : RUN;
                cnt_nxt   = last_rd ? CNT_W'(DRAIN_CYCLES - 1) : cnt;
            end
            DRAIN: begin
                state_nxt = cnt == '0 ? IDLE : DRAIN;
                pc_nxt    = cnt == '0 ? '0 : pc;
                cnt_nxt   = cnt == '0 ? cnt : cnt - 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame registers; last_rd flags that the read now returning was the final program word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pc      <= '0;
            cnt     <= '0;
            last_pc <= '0;
            last_rd <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            cnt     <= cnt_nxt;
            last_pc <= start ? bus.prog_last : last_pc;
            last_rd <= (state == FETCH || state == RUN) && pc == last_pc;
        end
    end

    // Sticky overrun; a new event outranks a same-cycle clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) overrun <= 1'b0;
        else overrun <= (bus.sample_tick && state != IDLE) || (overrun && !bus.overrun_clr);
    end

    assign bus.prog_rd_addr = pc;
    assign bus.instruction  = state == RUN ? bus.prog_rd_data : INSTR_WIDTH'(INSTR_NOP);
    assign bus.busy         = state != IDLE;
    assign bus.frame_done   = state == DRAIN && cnt == '0;
    assign bus.overrun      = overrun;
endmodule

// File: tb/tb_dsp_sequencer.sv
// tb_dsp_sequencer: scoreboard bench for the frame sequencer
module tb_dsp_sequencer;
    localparam int IW = 26;
    localparam int PW = 10;
    localparam int D  = 4;

    typedef struct {
        logic [IW-1:0] instr;
        logic          busy;
        logic          done;
        logic          chk_addr;
        logic [PW-1:0] addr;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    logic mon_en = 1'b0;
    logic [IW-1:0] mem [1024];
    exp_t exp_q [$];
    int checks = 0;
    int errors = 0;

    dsp_sequencer_if #(.INSTR_WIDTH(IW), .PC_WIDTH(PW)) bus ();

    dsp_sequencer #(.INSTR_WIDTH(IW), .PC_WIDTH(PW), .DRAIN_CYCLES(D)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.prog_rd_data <= mem[bus.prog_rd_addr];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        exp_t r;
        #1;
        if (mon_en) begin
            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                check("instr", 32'(bus.instruction), 32'(r.instr));
                check("busy", 32'(bus.busy), 32'(r.busy));
                check("frame_done", 32'(bus.frame_done), 32'(r.done));
                if (r.chk_addr) check("rd_addr", 32'(bus.prog_rd_addr), 32'(r.addr));
            end else begin
                check("idle_instr", 32'(bus.instruction), 0);
                check("idle_busy", 32'(bus.busy), 0);
                check("idle_done", 32'(bus.frame_done), 0);
            end
        end
    end

    task automatic start_frame(input int last);
        @(negedge clk);
        bus.prog_last   = PW'(last);
        bus.sample_tick = 1'b1;
        for (int j = 0; j <= last + 1 + D; j++) begin
            exp_t r;
            r.instr    = (j >= 1 && j <= last + 1) ? mem[j-1] : '0;
            r.busy     = 1'b1;
            r.done     = j == last + 1 + D;
            r.chk_addr = j <= last + 1;
            r.addr     = PW'(j > last ? last : j);
            exp_q.push_back(r);
        end
        @(negedge clk);
        bus.sample_tick = 1'b0;
        bus.prog_last   = PW'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 1100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("timeout", 32'(exp_q.size()), 0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        bus.enable      = 1'b1;
        bus.sample_tick = 1'b0;
        bus.overrun_clr = 1'b0;
        bus.prog_last   = '0;
        reset_n         = 1'b1;
        foreach (mem[i]) mem[i] = {6'($urandom_range(1, 63)), 20'($urandom)};
        #3 reset_n = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_instr", 32'(bus.instruction), 0);
        check("rst_done", 32'(bus.frame_done), 0);
        check("rst_overrun", 32'(bus.overrun), 0);
        check("rst_addr", 32'(bus.prog_rd_addr), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        @(negedge clk);
        start_frame(3);
        wait_idle();
        start_frame(0);
        wait_idle();
        bus.enable      = 1'b0;
        bus.sample_tick = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
        check("disabled_busy", 32'(bus.busy), 0);
        bus.enable = 1'b1;
        repeat (3) @(negedge clk);
        start_frame(6);
        bus.enable = 1'b0;
        wait_idle();
        bus.enable = 1'b1;
        start_frame(5);
        repeat (2) @(negedge clk);
        check("ovr_before", 32'(bus.overrun), 0);
        bus.sample_tick = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
        check("ovr_set", 32'(bus.overrun), 1);
        bus.sample_tick = 1'b1;
        bus.overrun_clr = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
        bus.overrun_clr = 1'b0;
        check("ovr_set_wins", 32'(bus.overrun), 1);
        wait_idle();
        check("ovr_sticky", 32'(bus.overrun), 1);
        bus.overrun_clr = 1'b1;
        @(negedge clk);
        bus.overrun_clr = 1'b0;
        check("ovr_clr", 32'(bus.overrun), 0);
        start_frame(1023);
        wait_idle();
        start_frame(7);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_instr", 32'(bus.instruction), 0);
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_done", 32'(bus.frame_done), 0);
        check("midrst_addr", 32'(bus.prog_rd_addr), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        start_frame(2);
        wait_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
